// File: rtl/a2d_pkg.sv
// Shared types and constants for the A2D SPI responder.
package a2d_pkg;

    typedef enum logic [1:0] {
        WAIT_HI = 2'd0,
        IDLE    = 2'd1,
        ARMED   = 2'd2,
        SHIFT   = 2'd3
    } resp_state_t;

    localparam int CMD_W        = 16;
    localparam int CHNL_MSB     = 13;
    localparam int CHNL_LSB     = 11;
    localparam int BITS_PER_FRM = 16;

    localparam logic [4:0] BIT_CNT_FRM = 5'd16;
    localparam logic [4:0] BIT_CNT_SAT = 5'd17;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer with a history flop for rise/fall detection.
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1_r;
    logic s2_r;
    logic s3_r;

    // Synchronizer chain plus history stage; cleared low so WAIT_HI sees a real high.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
            s3_r <= 1'b0;
        end else begin
            s1_r <= d;
            s2_r <= s1_r;
            s3_r <= s2_r;
        end
    end

    assign level = s2_r;
    assign rise  = s2_r & ~s3_r;
    assign fall  = ~s2_r & s3_r;

endmodule

// File: rtl/a2d_spi_resp.sv
// SPI responder emulating an 8-channel 12-bit A2D; each frame returns the
// channel selected by the previous valid command.
module a2d_spi_resp
    import a2d_pkg::*;
#(
    parameter int DATA_W = 12,
    parameter int NUM_CH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       SS_n,
    input  logic                       SCLK,
    input  logic                       MOSI,
    output logic                       MISO,
    input  logic [NUM_CH*DATA_W-1:0]   ch_data,
    output logic [CMD_W-1:0]           cmd,
    output logic                       cmd_vld,
    output logic                       frm_err,
    output logic [2:0]                 chnl
);

    logic ss_lvl, ss_rise, ss_fall;
    logic sclk_lvl, sclk_rise, sclk_fall;
    logic mosi_lvl, mosi_rise, mosi_fall;
    logic unused_sync;

    sync_edge_det u_ss   (.clk(clk), .rst(rst), .d(SS_n), .level(ss_lvl),   .rise(ss_rise),   .fall(ss_fall));
    sync_edge_det u_sclk (.clk(clk), .rst(rst), .d(SCLK), .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall));
    sync_edge_det u_mosi (.clk(clk), .rst(rst), .d(MOSI), .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall));

    assign unused_sync = ^{sclk_lvl, mosi_rise, mosi_fall};

    resp_state_t       state_r,    state_n;
    logic [4:0]        bit_cnt_r,  bit_cnt_n;
    logic [CMD_W-1:0]  cmd_shft_r, cmd_shft_n;
    logic [CMD_W-1:0]  resp_shft_r, resp_shft_n;
    logic [CMD_W-1:0]  cmd_r,      cmd_n;
    logic [2:0]        chnl_r,     chnl_n;
    logic              cmd_vld_r,  cmd_vld_n;
    logic              frm_err_r,  frm_err_n;
    logic              miso_r,     miso_n;
    logic [DATA_W-1:0] sample_s;

    assign sample_s = ch_data[int'(chnl_r)*DATA_W +: DATA_W];

    // Frame sequencing: an SS_n rise outranks any SCLK edge seen in the same clk.
    always_comb begin
        state_n     = state_r;
        bit_cnt_n   = bit_cnt_r;
        cmd_shft_n  = cmd_shft_r;
        resp_shft_n = resp_shft_r;
        cmd_n       = cmd_r;
        chnl_n      = chnl_r;
        cmd_vld_n   = 1'b0;
        frm_err_n   = 1'b0;
        case (state_r)
            WAIT_HI: begin
                if (ss_lvl) begin
                    state_n = IDLE;
                end else begin
                    state_n = WAIT_HI;
                end
            end
            IDLE: begin
                if (ss_fall) begin
                    resp_shft_n = {{(CMD_W-DATA_W){1'b0}}, sample_s};
                    bit_cnt_n   = 5'd0;
                    state_n     = ARMED;
                end else begin
                    state_n = IDLE;
                end
            end
            ARMED, SHIFT: begin
                if (ss_rise) begin
                    if (bit_cnt_r == BIT_CNT_FRM) begin
                        cmd_n     = cmd_shft_r;
                        chnl_n    = cmd_shft_r[CHNL_MSB:CHNL_LSB];
                        cmd_vld_n = 1'b1;
                    end else begin
                        frm_err_n = 1'b1;
                    end
                    state_n = IDLE;
                end else if (sclk_rise) begin
                    cmd_shft_n = {cmd_shft_r[CMD_W-2:0], mosi_lvl};
                    if (state_r == ARMED) begin
                        bit_cnt_n = 5'd1;
                    end else if (bit_cnt_r < BIT_CNT_SAT) begin
                        bit_cnt_n = bit_cnt_r + 5'd1;
                    end else begin
                        bit_cnt_n = BIT_CNT_SAT;
                    end
                    state_n = SHIFT;
                end else if (sclk_fall && (state_r == SHIFT) &&
                             (bit_cnt_r != 5'd0) && (bit_cnt_r < BIT_CNT_FRM)) begin
                    resp_shft_n = {resp_shft_r[CMD_W-2:0], 1'b0};
                end else begin
                    state_n = state_r;
                end
            end
            default: begin
                state_n = WAIT_HI;
            end
        endcase
        if ((state_n == ARMED) || (state_n == SHIFT)) begin
            miso_n = resp_shft_n[CMD_W-1];
        end else begin
            miso_n = 1'b0;
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= WAIT_HI;
            bit_cnt_r   <= 5'd0;
            cmd_shft_r  <= {CMD_W{1'b0}};
            resp_shft_r <= {CMD_W{1'b0}};
            cmd_r       <= {CMD_W{1'b0}};
            chnl_r      <= 3'd0;
            cmd_vld_r   <= 1'b0;
            frm_err_r   <= 1'b0;
            miso_r      <= 1'b0;
        end else begin
            state_r     <= state_n;
            bit_cnt_r   <= bit_cnt_n;
            cmd_shft_r  <= cmd_shft_n;
            resp_shft_r <= resp_shft_n;
            cmd_r       <= cmd_n;
            chnl_r      <= chnl_n;
            cmd_vld_r   <= cmd_vld_n;
            frm_err_r   <= frm_err_n;
            miso_r      <= miso_n;
        end
    end

    assign MISO    = miso_r;
    assign cmd     = cmd_r;
    assign cmd_vld = cmd_vld_r;
    assign frm_err = frm_err_r;
    assign chnl    = chnl_r;

endmodule

// File: tb/tb_a2d_spi_resp.sv
// Self-checking bench: directed vector table, hand-written corner sequences,
// and random frames checked against a frame-level reference model.
module tb_a2d_spi_resp;

    localparam int DATA_W = 12;
    localparam int NUM_CH = 8;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     SS_n;
    logic                     SCLK;
    logic                     MOSI;
    logic                     MISO;
    logic [NUM_CH*DATA_W-1:0] ch_data;
    logic [15:0]              cmd;
    logic                     cmd_vld;
    logic                     frm_err;
    logic [2:0]               chnl;

    a2d_spi_resp #(.DATA_W(DATA_W), .NUM_CH(NUM_CH)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .ch_data(ch_data), .cmd(cmd), .cmd_vld(cmd_vld), .frm_err(frm_err), .chnl(chnl)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int vld_tot = 0;
    int err_tot = 0;

    // Count every clk in which a pulse output is high.
    always @(negedge clk) begin
        if (cmd_vld === 1'b1) vld_tot++;
        if (frm_err === 1'b1) err_tot++;
    end

    typedef struct {
        logic [15:0] word;
        int          nbits;
        logic [15:0] exp_rd;
        logic        exp_vld;
        logic        exp_err;
        logic [15:0] exp_cmd;
        logic [2:0]  exp_chnl;
    } vec_t;

    vec_t        tbl [10];
    logic [11:0] ch_val [NUM_CH];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(input int i, input logic [11:0] v);
        ch_val[i] = v;
        ch_data[i*DATA_W +: DATA_W] = v;
    endtask

    task automatic frame(input logic [15:0] word, input int nbits, output logic [15:0] rd);
        rd   = 16'h0000;
        SS_n = 1'b0;
        wclk(8);
        for (int i = 0; i < nbits; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? word[15-i] : 1'b0;
            wclk(8);
            if (i < 16) rd[15-i] = MISO;
            SCLK = 1'b1;
            wclk(8);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        wclk(8);
    endtask

    task automatic run_frame(input string name, input logic [15:0] word, input int nbits,
                             input logic [15:0] exp_rd, input logic exp_vld, input logic exp_err,
                             input logic [15:0] exp_cmd, input logic [2:0] exp_chnl);
        logic [15:0] rd;
        logic [31:0] m;
        int          nb;
        int          v0;
        int          e0;
        v0 = vld_tot;
        e0 = err_tot;
        frame(word, nbits, rd);
        nb = (nbits > 16) ? 16 : nbits;
        m  = 32'hFFFF_0000 >> nb;
        chk({name, ".rd"},      {16'h0, rd & m[15:0]},  {16'h0, exp_rd & m[15:0]});
        chk({name, ".cmd_vld"}, vld_tot - v0,           {31'h0, exp_vld});
        chk({name, ".frm_err"}, err_tot - e0,           {31'h0, exp_err});
        chk({name, ".cmd"},     {16'h0, cmd},           {16'h0, exp_cmd});
        chk({name, ".chnl"},    {29'h0, chnl},          {29'h0, exp_chnl});
    endtask

    initial begin
        logic        acc;
        int          v0;
        int          e0;
        logic [15:0] m_cmd;
        logic [2:0]  m_chnl;
        logic [15:0] word;
        logic [15:0] exp_rd;
        int          nbits;

        tbl[0] = '{16'h0000, 16, 16'h0ABC, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[1] = '{16'h2000, 16, 16'h0ABC, 1'b1, 1'b0, 16'h2000, 3'd4};
        tbl[2] = '{16'h0000, 16, 16'h0123, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[3] = '{16'h2800, 16, 16'h0ABC, 1'b1, 1'b0, 16'h2800, 3'd5};
        tbl[4] = '{16'h1234, 16, 16'h0FFF, 1'b1, 1'b0, 16'h1234, 3'd2};
        tbl[5] = '{16'h2000,  8, 16'h0500, 1'b0, 1'b1, 16'h1234, 3'd2};
        tbl[6] = '{16'h0000, 16, 16'h05A5, 1'b1, 1'b0, 16'h0000, 3'd0};
        tbl[7] = '{16'h3FFF, 16, 16'h0ABC, 1'b1, 1'b0, 16'h3FFF, 3'd7};
        tbl[8] = '{16'h0000,  0, 16'h0000, 1'b0, 1'b1, 16'h3FFF, 3'd7};
        tbl[9] = '{16'hC000, 16, 16'h0864, 1'b1, 1'b0, 16'hC000, 3'd0};

        rst  = 1'b1;
        SS_n = 1'b1;
        SCLK = 1'b1;
        MOSI = 1'b0;
        ch_data = '0;
        set_ch(0, 12'hABC); set_ch(1, 12'h314); set_ch(2, 12'h5A5); set_ch(3, 12'h777);
        set_ch(4, 12'h123); set_ch(5, 12'hFFF); set_ch(6, 12'h0F0); set_ch(7, 12'h864);
        wclk(4);
        chk("reset.MISO",    {31'h0, MISO},    32'h0);
        chk("reset.cmd",     {16'h0, cmd},     32'h0);
        chk("reset.cmd_vld", {31'h0, cmd_vld}, 32'h0);
        chk("reset.frm_err", {31'h0, frm_err}, 32'h0);
        chk("reset.chnl",    {29'h0, chnl},    32'h0);
        rst = 1'b0;
        wclk(8);

        for (int i = 0; i < 10; i++) begin
            run_frame($sformatf("vec%0d", i), tbl[i].word, tbl[i].nbits, tbl[i].exp_rd,
                      tbl[i].exp_vld, tbl[i].exp_err, tbl[i].exp_cmd, tbl[i].exp_chnl);
        end

        // Reset in the middle of a frame while SS_n stays low.
        set_ch(0, 12'hFFF);
        SS_n = 1'b0;
        wclk(8);
        for (int i = 0; i < 6; i++) begin
            SCLK = 1'b0; wclk(8); SCLK = 1'b1; wclk(8);
        end
        rst = 1'b1;
        wclk(2);
        rst = 1'b0;
        wclk(2);
        chk("rstmid.MISO", {31'h0, MISO}, 32'h0);
        v0  = vld_tot;
        e0  = err_tot;
        acc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; wclk(8);
            acc = acc | MISO;
            SCLK = 1'b1; wclk(8);
        end
        SS_n = 1'b1;
        MOSI = 1'b0;
        wclk(8);
        chk("rstmid.miso_quiet", {31'h0, acc}, 32'h0);
        chk("rstmid.no_vld",     vld_tot - v0, 32'h0);
        chk("rstmid.no_err",     err_tot - e0, 32'h0);
        chk("rstmid.cmd",        {16'h0, cmd}, 32'h0);
        chk("rstmid.chnl",       {29'h0, chnl}, 32'h0);
        run_frame("rstmid.next", 16'h0000, 16, 16'h0FFF, 1'b1, 1'b0, 16'h0000, 3'd0);

        // Sample snapshot: ch0 changes one SCLK period after SS_n falls.
        set_ch(0, 12'h111);
        fork
            run_frame("snap.first", 16'h0000, 16, 16'h0111, 1'b1, 1'b0, 16'h0000, 3'd0);
            begin
                wclk(24);
                set_ch(0, 12'h222);
            end
        join
        run_frame("snap.second", 16'h0000, 16, 16'h0222, 1'b1, 1'b0, 16'h0000, 3'd0);

        // Random frames against the frame-level model.
        m_cmd  = 16'h0000;
        m_chnl = 3'd0;
        for (int n = 0; n < 40; n++) begin
            for (int c = 0; c < NUM_CH; c++) set_ch(c, 12'($urandom));
            word  = 16'($urandom);
            nbits = ($urandom_range(0, 9) < 7) ? 16 : int'($urandom_range(0, 17));
            exp_rd = {4'h0, ch_val[m_chnl]};
            if (nbits == 16) begin
                m_cmd  = word;
                m_chnl = word[13:11];
            end
            run_frame($sformatf("rnd%0d", n), word, nbits, exp_rd,
                      (nbits == 16), (nbits != 16), m_cmd, m_chnl);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
